// File: rtl/rfphoenix_mt_insn_queue.sv
// Multi-thread decoded-instruction queue between decode and issue.
// NTHR independent FIFOs of DEP entries share one distributed RAM, addressed
// as {tid, ptr[AW-1:0]}. One enqueue and one dequeue per cycle, each steered
// by its own thread id. Each thread has a flush, a true-full count (0..DEP),
// a sticky overflow flag and a registered, valid-qualified output.
//
// Handshake: there is no ready signal. A request (wr or rd) takes effect only
// when it is accepted, and acceptance is decided from start-of-cycle state.
// A write is accepted when the target thread is not full and not being flushed.
// A read is accepted when the target thread is not empty and not being flushed.
// A write that hits a full thread (and no flush) is dropped and sets that
// thread's ovf. The data for an accepted read appears on dout one cycle later,
// qualified by dout_v. Requests naming a thread id >= NTHR are ignored.
module rfphoenix_mt_insn_queue #(
    parameter int W         = 64,
    parameter int DEP       = 16,
    parameter int NTHR      = 4,
    parameter int AF_MARGIN = 6,
    localparam int AW       = $clog2(DEP),
    localparam int TW       = $clog2(NTHR),
    localparam int CW       = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [TW-1:0]     wr_tid,
    input  logic [W-1:0]      din,
    input  logic              rd,
    input  logic [TW-1:0]     rd_tid,
    input  logic [NTHR-1:0]   flush,
    output logic [W-1:0]      dout,
    output logic [TW-1:0]     dout_tid,
    output logic              dout_v,
    output logic [NTHR*CW-1:0] cnt,
    output logic [NTHR-1:0]   empty,
    output logic [NTHR-1:0]   full,
    output logic [NTHR-1:0]   almost_full,
    output logic              any_v,
    output logic [NTHR-1:0]   ovf
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEP);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEP - AF_MARGIN);

    // Shared payload storage; contents are deliberately not reset.
    logic [W-1:0] mem [NTHR*DEP];

    logic [CW-1:0] wr_ptr [NTHR];
    logic [CW-1:0] rd_ptr [NTHR];
    logic [CW-1:0] occ    [NTHR];

    logic [NTHR-1:0] wr_acc;
    logic [NTHR-1:0] wr_rej;
    logic [NTHR-1:0] rd_acc;
    logic [CW-1:0]   wr_sel;
    logic [CW-1:0]   rd_sel;
    logic            wr_any;
    logic            rd_any;

    // Occupancy and status flags, derived from the current pointers.
    always_comb begin
        cnt         = '0;
        empty       = '0;
        full        = '0;
        almost_full = '0;
        for (int t = 0; t < NTHR; t++) begin
            occ[t]                = wr_ptr[t] - rd_ptr[t];
            cnt[t*CW +: CW]       = occ[t];
            empty[t]              = (occ[t] == '0);
            full[t]               = (occ[t] == FULL_CNT);
            almost_full[t]        = (occ[t] >= AF_CNT);
        end
        any_v = |(~empty);
    end

    // Per-thread request decode; out-of-range ids never match any thread.
    always_comb begin
        wr_acc = '0;
        wr_rej = '0;
        rd_acc = '0;
        wr_sel = '0;
        rd_sel = '0;
        for (int t = 0; t < NTHR; t++) begin
            if (wr && (wr_tid == TW'(t))) begin
                wr_acc[t] = !full[t] && !flush[t];
                wr_rej[t] =  full[t] && !flush[t];
                wr_sel    = wr_ptr[t];
            end
            if (rd && (rd_tid == TW'(t))) begin
                rd_acc[t] = !empty[t] && !flush[t];
                rd_sel    = rd_ptr[t];
            end
        end
        wr_any = |wr_acc;
        rd_any = |rd_acc;
    end

    // RAM write port: store accepted enqueues (reset aborts the write).
    always_ff @(posedge clk) begin
        if (!rst && wr_any) begin
            mem[{wr_tid, wr_sel[AW-1:0]}] <= din;
        end
    end

    // Pointer, overflow and flush bookkeeping for every thread.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHR; t++) begin
                wr_ptr[t] <= '0;
                rd_ptr[t] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int t = 0; t < NTHR; t++) begin
                if (flush[t]) begin
                    rd_ptr[t] <= wr_ptr[t];
                    ovf[t]    <= 1'b0;
                end else begin
                    if (wr_acc[t]) wr_ptr[t] <= wr_ptr[t] + CW'(1);
                    if (rd_acc[t]) rd_ptr[t] <= rd_ptr[t] + CW'(1);
                    if (wr_rej[t]) ovf[t]    <= 1'b1;
                end
            end
        end
    end

    // Registered output: capture data for an accepted read, else drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= '0;
            dout_tid <= '0;
            dout_v   <= 1'b0;
        end else begin
            dout_v <= rd_any;
            if (rd_any) begin
                dout     <= mem[{rd_tid, rd_sel[AW-1:0]}];
                dout_tid <= rd_tid;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_mt_insn_queue.sv
// Directed bench for rfphoenix_mt_insn_queue (W=32, DEP=16, NTHR=4, AF_MARGIN=6).
module tb_rfphoenix_mt_insn_queue;

    localparam int W    = 32;
    localparam int DEP  = 16;
    localparam int NTHR = 4;
    localparam int AW   = 4;
    localparam int TW   = 2;
    localparam int CW   = AW + 1;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              wr = 1'b0;
    logic [TW-1:0]     wr_tid = '0;
    logic [W-1:0]      din = '0;
    logic              rd = 1'b0;
    logic [TW-1:0]     rd_tid = '0;
    logic [NTHR-1:0]   flush = '0;
    logic [W-1:0]      dout;
    logic [TW-1:0]     dout_tid;
    logic              dout_v;
    logic [NTHR*CW-1:0] cnt;
    logic [NTHR-1:0]   empty;
    logic [NTHR-1:0]   full;
    logic [NTHR-1:0]   almost_full;
    logic              any_v;
    logic [NTHR-1:0]   ovf;

    rfphoenix_mt_insn_queue #(.W(W), .DEP(DEP), .NTHR(NTHR), .AF_MARGIN(6)) dut (
        .clk(clk), .rst(rst),
        .wr(wr), .wr_tid(wr_tid), .din(din),
        .rd(rd), .rd_tid(rd_tid), .flush(flush),
        .dout(dout), .dout_tid(dout_tid), .dout_v(dout_v),
        .cnt(cnt), .empty(empty), .full(full), .almost_full(almost_full),
        .any_v(any_v), .ovf(ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_d;

    // Scoreboard comparison point
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] c(input int t);
        return cnt[t*CW +: CW];
    endfunction

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input int wt, input logic [W-1:0] d,
                         input logic r, input int rt, input logic [NTHR-1:0] f);
        wr = w; wr_tid = TW'(wt); din = d; rd = r; rd_tid = TW'(rt); flush = f;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_cnt", cnt, 0);
        check("rst_empty", empty, 4'hF);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_anyv", any_v, 0);
        check("rst_dout", dout, 0);
        check("rst_dtid", dout_tid, 0);
        check("rst_doutv", dout_v, 0);
        check("rst_ovf", ovf, 0);

        // 1. Fill thread 1
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 32'hA0 + i, 0, 0, 0);
            cyc();
            check("fill_cnt1", c(1), i + 1);
            check("fill_af1", almost_full[1], (i + 1) >= 10);
        end
        check("fill_full", full, 4'b0010);
        check("fill_empty", empty, 4'b1101);
        check("fill_anyv", any_v, 1);

        // 2. Overflow, then drain thread 1 in order
        drive(1, 1, 32'hFF, 0, 0, 0);
        cyc();
        check("ovf_flag", ovf, 4'b0010);
        check("ovf_cnt1", c(1), 16);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            cyc();
            check("drain_v", dout_v, 1);
            check("drain_d", dout, 32'hA0 + i);
            check("drain_tid", dout_tid, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("drain_idle_v", dout_v, 0);
        check("drain_cnt1", c(1), 0);
        check("drain_hold", dout, 32'hAF);

        // 3. Interleave: write t0 + read empty t2, then write t2 + read t0
        drive(1, 0, 32'h10, 1, 2, 0);
        cyc();
        check("il_v0", dout_v, 0);
        check("il_cnt0", c(0), 1);
        check("il_hold", dout, 32'hAF);
        drive(1, 2, 32'h20, 1, 0, 0);
        cyc();
        check("il_v1", dout_v, 1);
        check("il_d", dout, 32'h10);
        check("il_tid", dout_tid, 0);
        check("il_cnt0b", c(0), 0);
        check("il_cnt2", c(2), 1);

        // 4. Fill t3 with 5, then flush t3 with same-cycle write and read
        for (int i = 0; i < 5; i++) begin
            drive(1, 3, 32'h30 + i, 0, 0, 0);
            cyc();
        end
        check("f_pre_cnt3", c(3), 5);
        drive(1, 3, 32'h3F, 1, 3, 4'b1000);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("f_cnt3", c(3), 0);
        check("f_v", dout_v, 0);
        check("f_ovf", ovf, 4'b0010);
        check("f_cnt0", c(0), 0);
        check("f_cnt1", c(1), 0);
        check("f_cnt2", c(2), 1);
        cyc();
        check("f_v_after", dout_v, 0);
        // flush of t1 clears its sticky overflow
        drive(0, 0, 0, 0, 0, 4'b0010);
        cyc();
        check("f_ovf_clr", ovf, 0);

        // 5. Pointer wrap on t0 at constant depth 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h100 + i, 0, 0, 0);
            exp_q.push_back(32'h100 + i);
            cyc();
        end
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 32'h103 + i, 1, 0, 0);
            exp_q.push_back(32'h103 + i);
            cyc();
            exp_d = exp_q.pop_front();
            check("wrap_v", dout_v, 1);
            check("wrap_d", dout, exp_d);
            check("wrap_cnt0", c(0), 3);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            cyc();
            exp_d = exp_q.pop_front();
            check("wrap_tail", dout, exp_d);
        end
        check("wrap_empty0", c(0), 0);

        // 6. Reset mid-stream
        for (int t = 0; t < NTHR; t++) begin
            for (int i = 0; i < 2; i++) begin
                drive(1, t, 32'h500 + t * 16 + i, 0, 0, 0);
                cyc();
            end
        end
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 32'h600 + i, 0, 0, 0);
            cyc();
        end
        check("m_ovf", ovf, 4'b0010);
        check("m_cnt1", c(1), 16);
        drive(0, 0, 0, 1, 0, 0);
        cyc();
        check("m_v", dout_v, 1);
        check("m_d", dout, 32'h500);
        rst = 1'b1;
        drive(1, 2, 32'h777, 1, 0, 0);
        cyc();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("mr_empty", empty, 4'hF);
        check("mr_cnt", cnt, 0);
        check("mr_v", dout_v, 0);
        check("mr_d", dout, 0);
        check("mr_ovf", ovf, 0);
        check("mr_anyv", any_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
